param_updown_counter: RTL and testbench

//   Parametrised synchronous up/down modulo counter. Next generation of the team's
//   4-bit ripple counter: configurable width/modulus, parallel load, count enable,

---
 rtl/param_updown_counter.sv | 90 +++++++++
 tb/tb_param_updown_counter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/param_updown_counter.sv
// Parametrised up/down modulo counter with parallel load, count enable and
// wrap / saturate / one-shot / hold run modes.
module param_updown_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 16,
  parameter int INIT    = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap,
  output logic             done
);

  typedef enum logic {ST_RUN, ST_DONE} state_t;

  localparam logic [WIDTH-1:0] MAX_V  = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] INIT_V = WIDTH'(INIT);
  localparam logic [WIDTH-1:0] ONE_V  = WIDTH'(1);

  logic [WIDTH-1:0] q_q, q_d;
  logic             wrap_q, wrap_d;
  state_t           state_q, state_d;

  logic             at_max, at_zero;
  logic [WIDTH-1:0] sat_up, sat_dn;

  assign at_max  = (q_q == MAX_V);
  assign at_zero = (q_q == '0);
  assign sat_up  = at_max  ? MAX_V : q_q + ONE_V;
  assign sat_dn  = at_zero ? '0    : q_q - ONE_V;

  always_comb begin
    q_d     = q_q;
    wrap_d  = 1'b0;
    state_d = state_q;
    if (load) begin
      q_d     = (load_val > MAX_V) ? MAX_V : load_val;
      state_d = ST_RUN;
    end else if (en) begin
      case (mode)
        2'b00: begin
          if (up) begin
            q_d    = at_max ? '0 : q_q + ONE_V;
            wrap_d = at_max;
          end else begin
            q_d    = at_zero ? MAX_V : q_q - ONE_V;
            wrap_d = at_zero;
          end
        end
        2'b01: q_d = up ? sat_up : sat_dn;
        2'b10: begin
          // Finishing is detected on the edge that reaches the terminal value,
          // or on the first enabled edge while already sitting on it.
          if (state_q == ST_RUN) begin
            q_d = up ? sat_up : sat_dn;
            if (up ? (sat_up == MAX_V) : (sat_dn == '0)) begin
              state_d = ST_DONE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_q     <= INIT_V;
      wrap_q  <= 1'b0;
      state_q <= ST_RUN;
    end else begin
      q_q     <= q_d;
      wrap_q  <= wrap_d;
      state_q <= state_d;
    end
  end

  assign q    = q_q;
  assign wrap = wrap_q;
  assign done = (state_q == ST_DONE);
  assign tc   = up ? at_max : at_zero;

endmodule

// File: tb/tb_param_updown_counter.sv
// Self-checking bench for param_updown_counter (WIDTH=4, MODULUS=10, INIT=0):
// directed scenarios plus randomized traffic against a behavioural model.
module tb_param_updown_counter;

  localparam int W   = 4;
  localparam int MOD = 10;
  localparam int MX  = MOD - 1;

  logic         clk;
  logic         reset;
  logic         en;
  logic         up;
  logic [1:0]   mode;
  logic         load;
  logic [W-1:0] load_val;
  logic [W-1:0] q;
  logic         tc;
  logic         wrap;
  logic         done;

  int checks = 0;
  int errors = 0;

  // behavioural model state
  int m_q    = 0;
  int m_wrap = 0;
  int m_done = 0;

  param_updown_counter #(.WIDTH(W), .MODULUS(MOD), .INIT(0)) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .up       (up),
    .mode     (mode),
    .load     (load),
    .load_val (load_val),
    .q        (q),
    .tc       (tc),
    .wrap     (wrap),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model of one clock edge using the inputs currently driven.
  task automatic model_step();
    int lv;
    lv = int'(load_val);
    if (load) begin
      m_q    = (lv > MX) ? MX : lv;
      m_done = 0;
      m_wrap = 0;
    end else if (!en) begin
      m_wrap = 0;
    end else begin
      m_wrap = 0;
      case (mode)
        2'd0: begin
          if (up) begin
            m_wrap = (m_q == MX) ? 1 : 0;
            m_q    = (m_q + 1) % MOD;
          end else begin
            m_wrap = (m_q == 0) ? 1 : 0;
            m_q    = (m_q + MOD - 1) % MOD;
          end
        end
        2'd1: m_q = up ? ((m_q + 1 > MX) ? MX : m_q + 1) : ((m_q - 1 < 0) ? 0 : m_q - 1);
        2'd2: begin
          if (m_done == 0) begin
            m_q = up ? ((m_q + 1 > MX) ? MX : m_q + 1) : ((m_q - 1 < 0) ? 0 : m_q - 1);
            if (m_q == (up ? MX : 0)) m_done = 1;
          end
        end
        default: ;
      endcase
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; en = 1'b0; up = 1'b1; mode = 2'b00; load = 1'b0; load_val = '0;
    #1;
    checks++; if (q !== 4'd0) begin errors++; $display("FAIL reset_q: got %0d expected 0", q); end
    checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL reset_wrap: got %b expected 0", wrap); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    @(negedge clk);
    reset = 1'b0; en = 1'b1;
    repeat (6) tick();
    checks++; if (q !== 4'd6) begin errors++; $display("FAIL reset_pre_q: got %0d expected 6", q); end
    #2 reset = 1'b1;
    #1;
    checks++; if (q !== 4'd0) begin errors++; $display("FAIL reset_async_q: got %0d expected 0", q); end
    checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL reset_async_wrap: got %b expected 0", wrap); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_async_done: got %b expected 0", done); end
    tick();
    checks++; if (q !== 4'd0) begin errors++; $display("FAIL reset_held_q: got %0d expected 0", q); end
    reset = 1'b0;
    tick();
    checks++; if (q !== 4'd1) begin errors++; $display("FAIL reset_resume1_q: got %0d expected 1", q); end
    tick();
    checks++; if (q !== 4'd2) begin errors++; $display("FAIL reset_resume2_q: got %0d expected 2", q); end
    $display("test_reset done q=%0d", q);
  endtask

  task automatic test_wrap_up();
    int e;
    mode = 2'b00; up = 1'b1; en = 1'b1; load = 1'b1; load_val = 4'd0;
    tick();
    load = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      e = i % MOD;
      checks++; if (q !== 4'(e)) begin errors++; $display("FAIL wrap_up_q[%0d]: got %0d expected %0d", i, q, e); end
      checks++; if (wrap !== (e == 0)) begin errors++; $display("FAIL wrap_up_wrap[%0d]: got %b expected %b", i, wrap, (e == 0)); end
      checks++; if (tc !== (e == MX)) begin errors++; $display("FAIL wrap_up_tc[%0d]: got %b expected %b", i, tc, (e == MX)); end
    end
    $display("test_wrap_up done q=%0d", q);
  endtask

  task automatic test_wrap_down();
    int exp_q[3]    = '{0, 9, 8};
    int exp_wrap[3] = '{0, 1, 0};
    int exp_tc[3]   = '{1, 0, 0};
    mode = 2'b00; up = 1'b0; en = 1'b1; load = 1'b1; load_val = 4'd1;
    tick();
    load = 1'b0;
    checks++; if (tc !== 1'b0) begin errors++; $display("FAIL wrap_dn_tc_start: got %b expected 0", tc); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (q !== 4'(exp_q[i])) begin errors++; $display("FAIL wrap_dn_q[%0d]: got %0d expected %0d", i, q, exp_q[i]); end
      checks++; if (wrap !== 1'(exp_wrap[i])) begin errors++; $display("FAIL wrap_dn_wrap[%0d]: got %b expected %0d", i, wrap, exp_wrap[i]); end
      checks++; if (tc !== 1'(exp_tc[i])) begin errors++; $display("FAIL wrap_dn_tc[%0d]: got %b expected %0d", i, tc, exp_tc[i]); end
    end
    $display("test_wrap_down done q=%0d", q);
  endtask

  task automatic test_saturate();
    int exp_q[5] = '{8, 9, 9, 9, 9};
    mode = 2'b01; up = 1'b1; en = 1'b1; load = 1'b1; load_val = 4'd7;
    tick();
    load = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (q !== 4'(exp_q[i])) begin errors++; $display("FAIL sat_up_q[%0d]: got %0d expected %0d", i, q, exp_q[i]); end
      checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL sat_up_wrap[%0d]: got %b expected 0", i, wrap); end
    end
    up = 1'b0; load = 1'b1; load_val = 4'd1;
    tick();
    load = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (q !== 4'd0) begin errors++; $display("FAIL sat_dn_q[%0d]: got %0d expected 0", i, q); end
      checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL sat_dn_wrap[%0d]: got %b expected 0", i, wrap); end
    end
    $display("test_saturate done q=%0d", q);
  endtask

  task automatic test_oneshot();
    int exp_q[5]    = '{4, 3, 2, 1, 0};
    int exp_done[5] = '{0, 0, 0, 0, 1};
    mode = 2'b10; up = 1'b0; en = 1'b1; load = 1'b1; load_val = 4'd5;
    tick();
    load = 1'b0;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL os_load_done: got %b expected 0", done); end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (q !== 4'(exp_q[i])) begin errors++; $display("FAIL os_q[%0d]: got %0d expected %0d", i, q, exp_q[i]); end
      checks++; if (done !== 1'(exp_done[i])) begin errors++; $display("FAIL os_done[%0d]: got %b expected %0d", i, done, exp_done[i]); end
    end
    for (int i = 0; i < 4; i++) begin
      en = 1'($urandom_range(0, 1));
      up = 1'(i);
      tick();
      checks++; if (q !== 4'd0) begin errors++; $display("FAIL os_hold_q[%0d]: got %0d expected 0", i, q); end
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL os_hold_done[%0d]: got %b expected 1", i, done); end
    end
    en = 1'b1; up = 1'b0; load = 1'b1; load_val = 4'd3;
    tick();
    load = 1'b0;
    checks++; if (q !== 4'd3) begin errors++; $display("FAIL os_reload_q: got %0d expected 3", q); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL os_reload_done: got %b expected 0", done); end
    tick();
    checks++; if (q !== 4'd2) begin errors++; $display("FAIL os_resume_q: got %0d expected 2", q); end
    $display("test_oneshot done q=%0d done=%b", q, done);
  endtask

  task automatic test_load();
    mode = 2'b00; up = 1'b1; en = 1'b0; load = 1'b1; load_val = 4'd12;
    tick();
    checks++; if (q !== 4'd9) begin errors++; $display("FAIL load_clamp_q: got %0d expected 9", q); end
    en = 1'b1; load_val = 4'd2;
    tick();
    checks++; if (q !== 4'd2) begin errors++; $display("FAIL load_over_en_q: got %0d expected 2", q); end
    checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL load_wrap: got %b expected 0", wrap); end
    load = 1'b0; mode = 2'b11;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (q !== 4'd2) begin errors++; $display("FAIL hold_q[%0d]: got %0d expected 2", i, q); end
      checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL hold_wrap[%0d]: got %b expected 0", i, wrap); end
    end
    $display("test_load done q=%0d", q);
  endtask

  task automatic test_random();
    int m_tc;
    load = 1'b1; load_val = 4'd0; en = 1'b0; mode = 2'b00; up = 1'b1;
    model_step();
    tick();
    for (int i = 0; i < 400; i++) begin
      load     = ($urandom_range(0, 9) == 0);
      load_val = 4'($urandom_range(0, 15));
      en       = ($urandom_range(0, 4) != 0);
      up       = 1'($urandom_range(0, 1));
      mode     = 2'($urandom_range(0, 3));
      if (m_done != 0 && !load && mode < 2'b10) mode = 2'($urandom_range(2, 3));
      model_step();
      tick();
      m_tc = up ? ((m_q == MX) ? 1 : 0) : ((m_q == 0) ? 1 : 0);
      checks++; if (q !== 4'(m_q)) begin errors++; $display("FAIL rand_q[%0d]: got %0d expected %0d", i, q, m_q); end
      checks++; if (wrap !== 1'(m_wrap)) begin errors++; $display("FAIL rand_wrap[%0d]: got %b expected %0d", i, wrap, m_wrap); end
      checks++; if (done !== 1'(m_done)) begin errors++; $display("FAIL rand_done[%0d]: got %b expected %0d", i, done, m_done); end
      checks++; if (tc !== 1'(m_tc)) begin errors++; $display("FAIL rand_tc[%0d]: got %b expected %0d", i, tc, m_tc); end
    end
    $display("test_random done q=%0d", q);
  endtask

  initial begin
    test_reset();
    test_wrap_up();
    test_wrap_down();
    test_saturate();
    test_oneshot();
    test_load();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
